ps2_frame_receiver: RTL and testbench

Receives 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) from the PS/2 clock/data lines and delivers each byte to system logic as a one-cycle strobe. It runs entirely on the system clock; the PS/2 lines are treated as asynchronous inputs. It sits directly downstream of the PS/2 frame transmitter in the PS/2 simulation bench and in the keyboard path, consuming the serial stream the transmitter produces.

---
 rtl/ps2_frame_receiver.sv | 161 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: synchronises and de-glitches the PS/2 clock/data lines,
// deserialises 11-bit frames and presents each good byte as a one-cycle strobe.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [3:0]  FILT_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_meta, clk_sync;
  logic                  dat_meta, dat_sync;
  logic [3:0]            filt_cnt;
  logic                  filt_clk, filt_clk_d;
  logic [FILTER_LEN-1:0] dat_dly;
  logic                  fall;
  logic                  bit_in;

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par;
  logic [15:0]           timer;

  // Both lines idle high, so the conditioning chain resets to 1 to avoid
  // manufacturing a falling edge as reset is released.
  // NOTE: reset here is synchronous, so it lives inside the clocked branch;
  // all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      dat_meta   <= 1'b1;
      dat_sync   <= 1'b1;
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk;
      clk_sync   <= clk_meta;
      dat_meta   <= ps2_data;
      dat_sync   <= dat_meta;
      filt_clk_d <= filt_clk;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // Data is delayed by the filter length so the bit sampled on a filtered
  // fall is the one that was on the line when the raw clock fell.
  // NOTE: this shift line is small and resettable; larger storage arrays
  // would normally be left without reset.
  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      dat_dly <= '1;
    end else begin
      dat_dly[0] <= dat_sync;
      for (int i = 1; i < FILTER_LEN; i++) begin
        dat_dly[i] <= dat_dly[i-1];
      end
    end
  end

  assign fall   = filt_clk_d & ~filt_clk;
  assign bit_in = dat_dly[FILTER_LEN-1];

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      timer      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) begin
        timer <= '0;
      end else begin
        timer <= timer + 16'd1;
      end

      // Timeout wins over a coincident fall, which is dropped.
      if (state != IDLE && timer == TIMER_LAST) begin
        state     <= IDLE;
        busy      <= 1'b0;
        timer     <= '0;
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par   <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!(^{shreg, par})) begin
              frame_err <= 1'b1;
              err_code  <= ERR_PARITY;
            end else if (!bit_in) begin
              frame_err <= 1'b1;
              err_code  <= ERR_STOP;
            end else begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: drives PS/2 frames bit by bit and
// checks strobes, error codes, latency and busy behaviour against hand values.
module tb_ps2_frame_receiver;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int PERIOD         = 10;
  localparam int HALF           = 50;
  localparam int LATENCY        = 2 + FILTER_LEN + 1;

  logic       CLK;
  logic       Resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  ps2_frame_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #(PERIOD/2) CLK = ~CLK;

  // Pulse monitor, sampling outputs on the falling system-clock edge.
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] dv_data = '0;
  logic [7:0] dv_data_prev = '0;
  logic [1:0] fe_code = '0;
  time        dv_time = 0;
  time        fe_time = 0;
  int         idle_run = 0;
  int         gap_at_dv = 0;
  logic       dv_q = 1'b0;
  logic       fe_q = 1'b0;
  logic       busy_q = 1'b0;
  logic       overlap_seen = 1'b0;
  logic       width_bad = 1'b0;
  logic       busy_edge_bad = 1'b0;

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt++;
      dv_data_prev = dv_data;
      dv_data      = data_out;
      dv_time      = $time;
      gap_at_dv    = idle_run;
      idle_run     = 0;
    end else if (!busy) begin
      idle_run++;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_code = err_code;
      fe_time = $time;
    end
    if (data_valid && frame_err) overlap_seen = 1'b1;
    if ((data_valid && dv_q) || (frame_err && fe_q)) width_bad = 1'b1;
    if ((data_valid || frame_err) && (busy || !busy_q)) busy_edge_bad = 1'b1;
    dv_q   = data_valid;
    fe_q   = frame_err;
    busy_q = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Frame bits LSB-first: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip_par,
                                           input logic stop);
    return {stop, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  time t_fall = 0;

  // Each bit: 50-cycle high phase (optional 2-cycle low glitch, data change
  // mid-phase) then a 50-cycle low phase. t_fall marks the last raw fall.
  task automatic send_bits(input logic [21:0] bits, input int nbits, input logic glitch);
    for (int i = 0; i < nbits; i++) begin
      wait_neg(12);
      if (glitch) ps2_clk = 1'b0;
      wait_neg(2);
      ps2_clk = 1'b1;
      wait_neg(11);
      ps2_data = bits[i];
      wait_neg(25);
      ps2_clk = 1'b0;
      t_fall  = $time;
      wait_neg(HALF);
      ps2_clk = 1'b1;
    end
    wait_neg(25);
    ps2_data = 1'b1;
    wait_neg(25);
  endtask

  task automatic settle(input int n);
    wait_neg(n);
    #1;
  endtask

  initial begin
    Resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    settle(5);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_err_code",   32'(err_code),   32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    @(negedge CLK);
    Resetn = 1'b1;
    settle(10);

    // Good byte and stop-fall-to-strobe latency.
    send_bits({11'b0, mk_frame(8'h1C, 1'b0, 1'b1)}, 11, 1'b0);
    settle(5);
    check("1c_dv_cnt",   32'(dv_cnt),   32'd1);
    check("1c_dv_data",  32'(dv_data),  32'h1C);
    check("1c_data_out", 32'(data_out), 32'h1C);
    check("1c_latency",  32'(dv_time - t_fall), 32'(LATENCY * PERIOD));
    check("1c_no_err",   32'(fe_cnt),   32'd0);

    // Back-to-back frames 0x00 then 0xFF, no idle gap on the line.
    send_bits({mk_frame(8'hFF, 1'b0, 1'b1), mk_frame(8'h00, 1'b0, 1'b1)}, 22, 1'b0);
    settle(5);
    check("b2b_dv_cnt", 32'(dv_cnt),       32'd3);
    check("b2b_first",  32'(dv_data_prev), 32'h00);
    check("b2b_second", 32'(dv_data),      32'hFF);
    check("b2b_busy_gap", 32'(gap_at_dv >= 1), 32'd1);

    // Parity error keeps the last good byte.
    send_bits({11'b0, mk_frame(8'hA5, 1'b1, 1'b1)}, 11, 1'b0);
    settle(5);
    check("par_fe_cnt",   32'(fe_cnt),   32'd1);
    check("par_fe_code",  32'(fe_code),  32'h1);
    check("par_err_code", 32'(err_code), 32'h1);
    check("par_hold",     32'(data_out), 32'hFF);
    check("par_no_dv",    32'(dv_cnt),   32'd3);

    // Stop-bit error.
    send_bits({11'b0, mk_frame(8'h3C, 1'b0, 1'b0)}, 11, 1'b0);
    settle(5);
    check("stop_fe_cnt",   32'(fe_cnt),   32'd2);
    check("stop_err_code", 32'(err_code), 32'h2);
    check("stop_hold",     32'(data_out), 32'hFF);

    // Clock stops after 4 data bits; the timeout counts from the internal
    // fall, which is registered LATENCY cycles after the raw edge.
    send_bits({11'b0, mk_frame(8'h5A, 1'b0, 1'b1)}, 5, 1'b0);
    settle(TIMEOUT_CYCLES);
    check("to_fe_cnt",   32'(fe_cnt),   32'd3);
    check("to_err_code", 32'(err_code), 32'h3);
    check("to_time",     32'(fe_time - t_fall), 32'((LATENCY + TIMEOUT_CYCLES) * PERIOD));
    check("to_busy",     32'(busy),     32'h0);
    send_bits({11'b0, mk_frame(8'h5A, 1'b0, 1'b1)}, 11, 1'b0);
    settle(5);
    check("to_next_dv",   32'(dv_cnt),  32'd4);
    check("to_next_data", 32'(dv_data), 32'h5A);

    // Short low glitches while idle and inside every high phase of a frame.
    ps2_clk = 1'b0;
    wait_neg(2);
    ps2_clk = 1'b1;
    settle(20);
    check("glitch_idle_busy", 32'(busy), 32'h0);
    send_bits({11'b0, mk_frame(8'h77, 1'b0, 1'b1)}, 11, 1'b1);
    settle(5);
    check("glitch_dv_cnt", 32'(dv_cnt),  32'd5);
    check("glitch_data",   32'(dv_data), 32'h77);
    check("glitch_no_err", 32'(fe_cnt),  32'd3);

    // Reset mid-frame, then a clean frame.
    send_bits({11'b0, mk_frame(8'h12, 1'b0, 1'b1)}, 6, 1'b0);
    Resetn = 1'b0;
    settle(3);
    check("mrst_data_out", 32'(data_out), 32'h00);
    check("mrst_err_code", 32'(err_code), 32'h0);
    check("mrst_busy",     32'(busy),     32'h0);
    @(negedge CLK);
    Resetn = 1'b1;
    settle(20);
    check("mrst_no_dv", 32'(dv_cnt), 32'd5);
    check("mrst_no_fe", 32'(fe_cnt), 32'd3);
    send_bits({11'b0, mk_frame(8'hC3, 1'b0, 1'b1)}, 11, 1'b0);
    settle(5);
    check("mrst_next_dv",   32'(dv_cnt),   32'd6);
    check("mrst_next_data", 32'(data_out), 32'hC3);

    check("pulse_overlap",   32'(overlap_seen),  32'h0);
    check("pulse_width",     32'(width_bad),     32'h0);
    check("busy_fall_align", 32'(busy_edge_bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
